// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: arbitrates stalls, taken branches and fault rollback to the last checkpoint.
// Optional fault event counter enabled by defining FAULT_LOG_EN.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 3,
    parameter int          MAX_RETRY    = 3,
    parameter int          CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             branch_valid,
    input  logic [31:0]      branch_target,
    input  logic             commit_valid,
    input  logic [31:0]      commit_pc,
    input  logic             fault_detect,
    output logic             pc_hold,
    output logic             pc_redirect,
    output logic [31:0]      redirect_addr,
    output logic             flush,
    output logic             recovery_active,
    output logic             fatal_error,
    output logic [CNT_W-1:0] fault_count
);

    typedef enum logic [1:0] {RUN, FLUSH, ROLLBACK, HALT} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [3:0] RETRY_LIM  = 4'(MAX_RETRY);

    state_t      state, state_nxt;
    logic [3:0]  flush_cnt, flush_cnt_nxt;
    logic [3:0]  retry_cnt, retry_cnt_nxt;
    logic [3:0]  retry_inc;
    logic [31:0] ckpt_pc, ckpt_pc_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_target, pend_target_nxt;

    logic        hold_d, redirect_d, flush_d, recovery_d, fatal_d;
    logic [31:0] addr_d;

    assign retry_inc = retry_cnt + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RUN;
            flush_cnt       <= 4'd0;
            retry_cnt       <= 4'd0;
            ckpt_pc         <= RESET_PC;
            pend_valid      <= 1'b0;
            pend_target     <= 32'd0;
            pc_hold         <= 1'b0;
            pc_redirect     <= 1'b0;
            redirect_addr   <= 32'd0;
            flush           <= 1'b0;
            recovery_active <= 1'b0;
            fatal_error     <= 1'b0;
        end else begin
            state           <= state_nxt;
            flush_cnt       <= flush_cnt_nxt;
            retry_cnt       <= retry_cnt_nxt;
            ckpt_pc         <= ckpt_pc_nxt;
            pend_valid      <= pend_valid_nxt;
            pend_target     <= pend_target_nxt;
            pc_hold         <= hold_d;
            pc_redirect     <= redirect_d;
            redirect_addr   <= addr_d;
            flush           <= flush_d;
            recovery_active <= recovery_d;
            fatal_error     <= fatal_d;
        end
    end

    // A commit and a fault in the same cycle: checkpoint moves, but the retry count still climbs.
    always_comb begin
        state_nxt       = state;
        flush_cnt_nxt   = flush_cnt;
        retry_cnt_nxt   = retry_cnt;
        ckpt_pc_nxt     = ckpt_pc;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        case (state)
            RUN: begin
                if (commit_valid) begin
                    ckpt_pc_nxt   = commit_pc + 32'd4;
                    retry_cnt_nxt = 4'd0;
                end
                if (fault_detect) begin
                    retry_cnt_nxt  = retry_inc;
                    pend_valid_nxt = 1'b0;
                    if (retry_inc >= RETRY_LIM) begin
                        state_nxt = HALT;
                    end else begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_INIT;
                    end
                end else if (stall_req) begin
                    if (branch_valid) begin
                        pend_valid_nxt  = 1'b1;
                        pend_target_nxt = branch_target;
                    end
                end else begin
                    pend_valid_nxt = 1'b0;
                end
            end
            FLUSH: begin
                flush_cnt_nxt = flush_cnt - 4'd1;
                if (flush_cnt <= 4'd1) begin
                    state_nxt = ROLLBACK;
                end
            end
            ROLLBACK: state_nxt = RUN;
            HALT:     state_nxt = HALT;
            default:  state_nxt = RUN;
        endcase
    end

    // Outputs are computed for the cycle after this edge, so hold always wins over redirect here.
    always_comb begin
        hold_d     = 1'b0;
        redirect_d = 1'b0;
        addr_d     = 32'd0;
        flush_d    = 1'b0;
        recovery_d = 1'b0;
        fatal_d    = 1'b0;
        case (state)
            RUN: begin
                if (state_nxt == HALT) begin
                    hold_d  = 1'b1;
                    flush_d = 1'b1;
                    fatal_d = 1'b1;
                end else if (state_nxt == FLUSH) begin
                    hold_d     = 1'b1;
                    flush_d    = 1'b1;
                    recovery_d = 1'b1;
                end else if (stall_req) begin
                    hold_d = 1'b1;
                end else if (branch_valid) begin
                    redirect_d = 1'b1;
                    addr_d     = branch_target;
                end else if (pend_valid) begin
                    redirect_d = 1'b1;
                    addr_d     = pend_target;
                end
            end
            FLUSH: begin
                recovery_d = 1'b1;
                if (state_nxt == ROLLBACK) begin
                    redirect_d = 1'b1;
                    addr_d     = ckpt_pc;
                end else begin
                    hold_d  = 1'b1;
                    flush_d = 1'b1;
                end
            end
            HALT: begin
                hold_d  = 1'b1;
                fatal_d = 1'b1;
            end
            default: begin
                hold_d = 1'b0;
            end
        endcase
    end

`ifdef FAULT_LOG_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] fault_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_cnt_q <= '0;
        end else if (state == RUN && fault_detect && fault_cnt_q != '1) begin
            fault_cnt_q <= fault_cnt_q + CNT_ONE;
        end
    end

    assign fault_count = fault_cnt_q;
`else
    assign fault_count = '0;
`endif

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Producer side of the PC control interface. Generates pc_hold, pc_redirect and redirect_addr for the PC register.
- Arbitrates three sources: pipeline stalls, taken branches, and fault-triggered rollback to the last committed checkpoint.
- Bounds consecutive rollbacks with a retry limit; when the limit is hit, parks the core in a fatal halt.
- Sits between hazard unit, branch unit, commit stage and fault detectors on one side, and the PC register on the other.

Parameters:
- RESET_PC, 32'h0000_0000, checkpoint value after reset; must match the PC register reset value.
- FLUSH_CYCLES, 3, cycles pc_hold and flush stay asserted during rollback (range 1..15).
- MAX_RETRY, 3, consecutive faults without an intervening commit before fatal halt (range 1..15).
- CNT_W, 8, width of the fault event counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_req  in  1  hazard unit requests PC freeze this cycle.
- branch_valid  in  1  taken branch/jump resolved this cycle.
- branch_target  in  32  target address for branch_valid.
- commit_valid  in  1  instruction retired without fault.
- commit_pc  in  32  PC of the retiring instruction.
- fault_detect  in  1  fault detected (TMR/parity mismatch); single-cycle pulse.
- pc_hold  out  1  freeze PC.
- pc_redirect  out  1  load redirect_addr into PC.
- redirect_addr  out  32  redirect target.
- flush  out  1  squash in-flight pipeline stages.
- recovery_active  out  1  high in FLUSH and ROLLBACK states.
- fatal_error  out  1  sticky retry-limit halt indication.
- fault_count  out  CNT_W  saturating fault counter (see Optional Feature).

Behaviour:
- All outputs are registered and respond 1 cycle after the input event.
- Reset (asynchronous, any state):
  - state=RUN; pc_hold=0, pc_redirect=0, redirect_addr=0, flush=0, recovery_active=0, fatal_error=0, fault_count=0.
  - ckpt_pc=RESET_PC; retry_cnt=0; pending branch cleared.
- Invariant: pc_hold and pc_redirect are never high in the same cycle, because the PC register gives hold priority and would drop the redirect.
- Checkpoint: in RUN, commit_valid loads ckpt_pc=commit_pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0) and clears retry_cnt. Commits in any other state are ignored.
- RUN state, priority from high to low:
  1. fault_detect: increment retry_cnt.
     - If the new value is >= MAX_RETRY, go to HALT.
     - Otherwise go to FLUSH and load a cycle counter with FLUSH_CYCLES.
     - A pending branch and any same-cycle branch_valid are discarded.
  2. stall_req: pc_hold=1 next cycle. A branch_valid arriving during the stall is latched as pending; a later branch_valid overwrites it.
  3. Redirect issue: if a branch is pending or branch_valid is high, assert pc_redirect=1 with redirect_addr=target for exactly 1 cycle, then clear pending. The pending branch issues in the first cycle stall_req is low.
  4. Otherwise all outputs are 0.
- FLUSH: pc_hold=1, flush=1, recovery_active=1 each cycle. Decrement the cycle counter; when it reaches 0, go to ROLLBACK. fault_detect and branch_valid are ignored.
- ROLLBACK (1 cycle): pc_redirect=1, redirect_addr=ckpt_pc, pc_hold=0, flush=0, recovery_active=1. Go to RUN. fault_detect in this cycle is ignored.
- HALT: pc_hold=1 and fatal_error=1 permanently, flush=1 for the first cycle only. All inputs are ignored; only reset exits.
- Simultaneous commit_valid and fault_detect in RUN: the checkpoint updates first, and the rollback targets the new ckpt_pc. retry_cnt still increments and is not cleared.
- Latency from fault_detect to PC loading ckpt_pc: FLUSH_CYCLES+2 cycles.

Optional Feature:
- Macro FAULT_LOG_EN.
- Defined: fault_count increments on every accepted fault_detect (RUN state only) and saturates at 2^CNT_W-1.
- Undefined: counter logic is omitted and fault_count is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset, then commit_valid with commit_pc=32'h100, then fault_detect -> FLUSH for 3 cycles (pc_hold=flush=1), then 1-cycle pc_redirect with redirect_addr=32'h104; pc_hold=0 in that cycle.
- stall_req high for 4 cycles with branch_valid and target 32'h200 in stall cycle 2 -> pc_redirect stays 0 during the stall; pc_redirect=1 with addr 32'h200 exactly one cycle after stall_req falls.
- Three fault_detect pulses with no commit between rollbacks (MAX_RETRY=3) -> first two perform rollback; third enters HALT: fatal_error=1, pc_hold=1 held for 20+ cycles until reset.
- fault_detect and branch_valid (target 32'h300) in the same cycle -> branch is dropped; rollback goes to ckpt_pc; 32'h300 never appears on redirect_addr.
- Assert reset mid-FLUSH -> next cycle all outputs are 0 and ckpt_pc=RESET_PC; a subsequent fault rolls back to 32'h0.
- With FAULT_LOG_EN and CNT_W=2: five faults, each followed by a commit -> fault_count reads 1, 2, 3, 3, 3. Without the macro -> fault_count stays 0.
